// File: rtl/board_state_ctl.sv
// board_state_ctl: tic-tac-toe board controller; turns mouse clicks into square occupancy/owner
// flags, tracks the turn and detects win/draw. Optional macro BOARD_CLICK_SYNC_EN adds a click synchronizer.
//
// state | meaning
// IDLE  | game screen inactive, board held clear
// PLAY  | waiting for a click on an empty square
// CHECK | one cycle: evaluate the 8 lines on the registered board
// OVER  | win or draw reached, board frozen until the next click

module board_state_ctl #(
    parameter int H_MAX = 1023,
    parameter int V_MAX = 767
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start_en,
    input  logic        choice_en,
    input  logic [11:0] mouse_xpos,
    input  logic [11:0] mouse_ypos,
    input  logic        mouse_left,
    output logic [8:0]  square_occ,
    output logic [8:0]  square_owner,
    output logic        turn,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [3:0]  moves
);

    typedef enum logic [1:0] {IDLE, PLAY, CHECK, OVER} state_t;

    localparam logic [11:0] H_LAST = 12'(H_MAX);
    localparam logic [11:0] V_LAST = 12'(V_MAX);

    state_t      state;
    logic        left_in;
    logic [11:0] xpos_in;
    logic [11:0] ypos_in;

`ifdef BOARD_CLICK_SYNC_EN
    logic        left_s1, left_s2;
    logic [11:0] x_s1, x_s2, y_s1, y_s2;

    // Coordinates ride alongside the synchronizer so each click keeps its own position.
    always_ff @(posedge pclk) begin
        if (rst) begin
            left_s1 <= 1'b0;
            left_s2 <= 1'b0;
            x_s1    <= 12'd0;
            x_s2    <= 12'd0;
            y_s1    <= 12'd0;
            y_s2    <= 12'd0;
        end else begin
            left_s1 <= mouse_left;
            left_s2 <= left_s1;
            x_s1    <= mouse_xpos;
            x_s2    <= x_s1;
            y_s1    <= mouse_ypos;
            y_s2    <= y_s1;
        end
    end

    assign left_in = left_s2;
    assign xpos_in = x_s2;
    assign ypos_in = y_s2;
`else
    assign left_in = mouse_left;
    assign xpos_in = mouse_xpos;
    assign ypos_in = mouse_ypos;
`endif

    logic        left_q;
    logic        click_q;
    logic [11:0] click_x;
    logic [11:0] click_y;

    always_ff @(posedge pclk) begin
        if (rst) begin
            left_q  <= 1'b0;
            click_q <= 1'b0;
            click_x <= 12'd0;
            click_y <= 12'd0;
        end else begin
            left_q  <= left_in;
            click_q <= left_in & ~left_q;
            click_x <= xpos_in;
            click_y <= ypos_in;
        end
    end

    logic [1:0] col, row;
    logic       col_ok, row_ok;
    logic [3:0] sq_idx;
    logic [8:0] sq_sel;
    logic       sq_free;

    always_comb begin
        col    = 2'd0;
        col_ok = 1'b1;
        if (click_x <= 12'd338)
            col = 2'd0;
        else if (click_x >= 12'd343 && click_x <= 12'd680)
            col = 2'd1;
        else if (click_x >= 12'd685 && click_x <= H_LAST)
            col = 2'd2;
        else
            col_ok = 1'b0;

        row    = 2'd0;
        row_ok = 1'b1;
        if (click_y <= 12'd252)
            row = 2'd0;
        else if (click_y >= 12'd257 && click_y <= 12'd510)
            row = 2'd1;
        else if (click_y >= 12'd515 && click_y <= V_LAST)
            row = 2'd2;
        else
            row_ok = 1'b0;
    end

    assign sq_idx  = {2'b00, row} * 4'd3 + {2'b00, col};
    assign sq_sel  = 9'd1 << sq_idx;
    assign sq_free = col_ok && row_ok && ((square_occ & sq_sel) == 9'd0);

    function automatic logic line_hit(input logic [8:0] b);
        line_hit = (b[0] & b[1] & b[2]) | (b[3] & b[4] & b[5]) | (b[6] & b[7] & b[8]) |
                   (b[0] & b[3] & b[6]) | (b[1] & b[4] & b[7]) | (b[2] & b[5] & b[8]) |
                   (b[0] & b[4] & b[8]) | (b[2] & b[4] & b[6]);
    endfunction

    logic win0, win1;
    assign win0 = line_hit(square_occ & ~square_owner);
    assign win1 = line_hit(square_occ & square_owner);

    always_ff @(posedge pclk) begin
        if (rst) begin
            state        <= IDLE;
            square_occ   <= 9'd0;
            square_owner <= 9'd0;
            turn         <= 1'b0;
            winner       <= 2'b00;
            game_over    <= 1'b0;
            moves        <= 4'd0;
        end else if (state != IDLE && (!start_en || choice_en)) begin
            // Leaving the game screen wins over any click in the same cycle.
            state        <= IDLE;
            square_occ   <= 9'd0;
            square_owner <= 9'd0;
            turn         <= 1'b0;
            winner       <= 2'b00;
            game_over    <= 1'b0;
            moves        <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_en && !choice_en)
                        state <= PLAY;
                end
                PLAY: begin
                    if (click_q && sq_free) begin
                        square_occ   <= square_occ | sq_sel;
                        square_owner <= turn ? (square_owner | sq_sel) : (square_owner & ~sq_sel);
                        turn         <= ~turn;
                        moves        <= moves + 4'd1;
                        state        <= CHECK;
                    end
                end
                CHECK: begin
                    if (win0 || win1) begin
                        winner    <= {win1, win0};
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else if (moves == 4'd9) begin
                        winner    <= 2'b11;
                        game_over <= 1'b1;
                        state     <= OVER;
                    end else begin
                        state <= PLAY;
                    end
                end
                OVER: begin
                    if (click_q) begin
                        square_occ   <= 9'd0;
                        square_owner <= 9'd0;
                        turn         <= 1'b0;
                        winner       <= 2'b00;
                        game_over    <= 1'b0;
                        moves        <= 4'd0;
                        state        <= PLAY;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/board_state_ctl.md
# board_state_ctl

Game-board controller for the tic-tac-toe display pipeline. It turns mouse clicks on the 1024x768 playing field into per-square occupancy and owner flags. It also tracks whose turn it is and detects a win or a draw. It sits directly upstream of the nine per-square draw stages: `square_occ[n-1]` drives each stage's `squareN` enable, and `square_owner[n-1]` drives its colour select (0 = BLUE, 1 = YELLOW).

## Interface
Parameters:
- `H_MAX`, 1023: last visible pixel column.
- `V_MAX`, 767: last visible pixel row.

Ports:
- `pclk` input 1: pixel clock, the single clock.
- `rst` input 1: synchronous, active-high reset.
- `start_en` input 1: game screen active.
- `choice_en` input 1: choice/menu screen active; suspends play.
- `mouse_xpos` input 12: cursor x, in pixels.
- `mouse_ypos` input 12: cursor y, in pixels.
- `mouse_left` input 1: left button level, 1 = pressed.
- `square_occ` output 9: bit n-1 = 1 means square n is taken. Squares are numbered 1..9 row-major, top-left to bottom-right; square 7 is bottom-left.
- `square_owner` output 9: bit n-1 gives the owner of square n; 0 = player 0 (BLUE), 1 = player 1 (YELLOW).
- `turn` output 1: player to move next.
- `winner` output 2: 00 = none, 01 = player 0, 10 = player 1, 11 = draw.
- `game_over` output 1: a win or a draw has been reached.
- `moves` output 4: number of squares taken, 0..9.

## Operation
- Columns:
  - col0: x 0..338.
  - col1: x 343..680.
  - col2: x 685..H_MAX.
- Rows:
  - row0: y 0..252.
  - row1: y 257..510.
  - row2: y 515..V_MAX.
- A click in a gap (x 339..342, 681..684; y 253..256, 511..514) is ignored. A click with x > H_MAX or y > V_MAX is also ignored.
- Click event: `mouse_left` is 1 and its previous sampled value is 0 (rising-edge detect).
- States:
  - IDLE: board, turn, winner, game_over and moves are held at 0. IDLE -> PLAY when `start_en` = 1 and `choice_en` = 0.
  - PLAY: a click on an empty square sets its occ bit, writes `turn` into its owner bit, toggles `turn`, increments `moves`, then -> CHECK. A click on an occupied square or outside the grid causes no change.
  - CHECK: one cycle. The 8 lines (3 rows, 3 columns, 2 diagonals) are evaluated on the registered board.
    - Three same-owner occupied squares in a line: `winner` = 01 or 10, `game_over` = 1, -> OVER.
    - Otherwise, if `moves` = 9: `winner` = 11, `game_over` = 1, -> OVER.
    - Otherwise -> PLAY.
  - OVER: the board is frozen. Any click clears the board, `turn`, `moves`, `winner` and `game_over`, then -> PLAY.
- From PLAY, CHECK or OVER: `start_en` = 0 or `choice_en` = 1 -> IDLE. This takes priority over a click in the same cycle, and the board is cleared on entry.
- Clicks arriving during CHECK or IDLE are dropped, not queued.

## Timing
- Reset (`rst` = 1 at a `pclk` edge):
  - all outputs = 0;
  - state = IDLE;
  - the click edge register is cleared.
- `rst` dominates every other input, including mid-move and mid-CHECK.
- All outputs are registered.
- A click edge sampled at edge N:
  - `square_occ`, `square_owner`, `turn` and `moves` are valid after edge N+1.
  - `winner` and `game_over` are valid after edge N+2.
- The minimum spacing between accepted moves is 2 cycles.
- Coordinates are sampled in the same cycle as the detected edge.
- Sources of `turn` and `winner`:
  - `turn` toggles only on an accepted move.
  - `winner` changes only in CHECK, on an OVER-exit click, or on entry to IDLE.
- Clear on an OVER click: the board reads 0 after edge N+1.

## Configuration
- `BOARD_CLICK_SYNC_EN`:
  - Defined: `mouse_left` passes through a 2-flop synchronizer before the edge detect. `mouse_xpos` and `mouse_ypos` are delayed by the same 2 stages so each click pairs with its coordinates. Every click-related latency grows by 2 cycles: board valid at N+3, result valid at N+4, where N is the edge at which `mouse_left` is sampled.
  - Undefined: `mouse_left` is edge-detected directly, with the latencies given under Timing.

## Test plan
- Reset, then `start_en` = 1 and `choice_en` = 0; click at (100, 600) → `square_occ` = 9'b001000000, `square_owner[6]` = 0, `turn` = 1, `moves` = 1, `winner` = 00.
- Second click at (100, 600), on the occupied square → no change to `square_occ`; `turn` stays 1.
- Click at (340, 100), in a gap → no change.
- Player 0 takes squares 1, 5, 9 while player 1 takes 2, 3 → two cycles after the 5th click, `winner` = 01 and `game_over` = 1. A further click clears the board and sets `turn` = 0.
- Fill all 9 squares with no line complete → `winner` = 11, `game_over` = 1, `moves` = 9.
- Raise `choice_en` mid-game, or assert `rst` in the CHECK cycle → next cycle all outputs = 0 and state = IDLE.
